sr_flipflop: RTL and testbench

Clocked SR flip-flop bank: on each rising clock edge every bit is set, cleared or held according to its own set/reset pair, with a complementary output. It is a leaf storage primitive used wherever set/clear-style status flags are needed. The default configuration is a single bit.

---
 rtl/sr_flipflop_pkg.sv | 16 +
 rtl/sr_flipflop_if.sv | 15 +
 rtl/sr_flipflop_bit.sv | 46 ++++
 rtl/sr_flipflop.sv | 25 ++
 tb/tb_sr_flipflop.sv | 133 +++++++++++++
 5 files changed

// File: rtl/sr_flipflop_pkg.sv
// Shared types and constants for the SR flip-flop bank.
package sr_flipflop_pkg;

  localparam int unsigned SR_CMD_W = 2;

  // Command formed as {s, r} for one bit.
  typedef enum logic [SR_CMD_W-1:0] {
    SR_HOLD    = 2'b00,
    SR_RESET   = 2'b01,
    SR_SET     = 2'b10,
    SR_INVALID = 2'b11
  } sr_cmd_e;

  localparam logic SR_RST_Q = 1'b0;

endpackage

// File: rtl/sr_flipflop_if.sv
// Bundle of the set/reset request and state signals of an SR flip-flop bank.
interface sr_flipflop_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             rst;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;

  modport master (output s, output r, output rst, input q, input qb);
  modport slave  (input s, input r, input rst, output q, output qb);

endinterface

// File: rtl/sr_flipflop_bit.sv
// Single-bit clocked SR cell with synchronous reset and complementary output.
// SR_FLIPFLOP_INVALID_X_EN makes the illegal 11 command drive x instead of holding.
module sr_flipflop_bit
  import sr_flipflop_pkg::*;
(
  input  logic s,
  input  logic r,
  input  logic clk,
  input  logic rst,
  output logic q,
  output logic qb
);

  logic    q_q;
  logic    q_d;
  sr_cmd_e cmd;

  assign cmd = sr_cmd_e'({s, r});

  always_comb begin
    q_d = q_q;
    case (cmd)
      SR_HOLD:    q_d = q_q;
      SR_RESET:   q_d = 1'b0;
      SR_SET:     q_d = 1'b1;
`ifdef SR_FLIPFLOP_INVALID_X_EN
      SR_INVALID: q_d = 1'bx;
`else
      SR_INVALID: q_d = q_q;
`endif
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SR_RST_Q;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/sr_flipflop.sv
// Bank of WIDTH independent clocked SR flip-flops with complementary outputs.
// Optional macro SR_FLIPFLOP_INVALID_X_EN (see sr_flipflop_bit) exposes illegal 11 commands as x.
module sr_flipflop #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_flipflop_bit u_bit (
      .s   (s[i]),
      .r   (r[i]),
      .clk (clk),
      .rst (rst),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

endmodule

// File: tb/tb_sr_flipflop.sv
// Scoreboard bench for sr_flipflop: a 1-bit default instance and a 4-bit instance share clk/rst.
module tb_sr_flipflop;

  logic        clk;
  int unsigned n_chk;
  int unsigned n_fail;

  sr_flipflop_if #(.WIDTH(1)) if1 ();
  sr_flipflop_if #(.WIDTH(4)) if4 ();

  sr_flipflop u_dut1 (
    .s   (if1.s),
    .r   (if1.r),
    .clk (clk),
    .rst (if1.rst),
    .q   (if1.q),
    .qb  (if1.qb)
  );

  sr_flipflop #(.WIDTH(4)) u_dut4 (
    .s   (if4.s),
    .r   (if4.r),
    .clk (clk),
    .rst (if4.rst),
    .q   (if4.q),
    .qb  (if4.qb)
  );

  typedef struct {
    string      tag;
    logic       q1;
    logic       qb1;
    logic [3:0] q4;
    logic [3:0] qb4;
  } exp_t;

  exp_t       sb[$];
  logic       m1;
  logic [3:0] m4;

  always #5 clk = ~clk;

  // Behavioural reference for one bit.
  function automatic logic model_bit(logic cur, logic s_v, logic r_v, logic rst_v);
    if (rst_v) return 1'b0;
    if (s_v && !r_v) return 1'b1;
    if (!s_v && r_v) return 1'b0;
    if (!s_v && !r_v) return cur;
`ifdef SR_FLIPFLOP_INVALID_X_EN
    return 1'bx;
`else
    return cur;
`endif
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 4'd1, 4'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_q1"},  {3'b000, if1.q},  {3'b000, e.q1});
      check({e.tag, "_qb1"}, {3'b000, if1.qb}, {3'b000, e.qb1});
      check({e.tag, "_q4"},  if4.q,  e.q4);
      check({e.tag, "_qb4"}, if4.qb, e.qb4);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, predict, and compare after the rising edge.
  task automatic drive(input string tag, input logic rst_v, input logic s1, input logic r1,
                       input logic [3:0] s4, input logic [3:0] r4);
    exp_t e;
    @(negedge clk);
    if1.rst = rst_v;
    if4.rst = rst_v;
    if1.s   = s1;
    if1.r   = r1;
    if4.s   = s4;
    if4.r   = r4;
    m1 = model_bit(m1, s1, r1, rst_v);
    for (int i = 0; i < 4; i++) m4[i] = model_bit(m4[i], s4[i], r4[i], rst_v);
    e.tag = tag;
    e.q1  = m1;
    e.qb1 = ~m1;
    e.q4  = m4;
    e.qb4 = ~m4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    clk    = 1'b0;
    n_chk  = 0;
    n_fail = 0;
    m1     = 1'bx;
    m4     = 4'bxxxx;
    if1.rst = 1'b1; if1.s = 1'b0; if1.r = 1'b0;
    if4.rst = 1'b1; if4.s = 4'h0; if4.r = 4'h0;

    drive("rst_over_set0", 1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
    drive("rst_over_set1", 1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) drive("hold_after_rst", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    drive("cmd_reset",     1'b0, 1'b0, 1'b1, 4'h0, 4'hF);
    drive("cmd_set",       1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
    drive("hold_one",      1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    drive("invalid",       1'b0, 1'b1, 1'b1, 4'b0011, 4'b0011);
    drive("recover",       1'b0, 1'b0, 1'b1, 4'h0, 4'hF);
    drive("set_again",     1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
    drive("rst_mid",       1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
    drive("rst_release",   1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
    drive("w4_mixed",      1'b0, 1'b0, 1'b0, 4'b0101, 4'b1010);
    drive("w4_set_msb",    1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000);

    for (int i = 0; i < 40; i++) begin
      drive("rand", ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
